alu_cmd_issuer: RTL and testbench
=================================

# alu_cmd_issuer

- Command-side counterpart of the ALU control decoder: accepts ALU commands (3-bit opcode plus two operands) on a valid/ready interface and drives the opcode and operands into the ALU datapath.
- Holds those inputs stable for a fixed number of cycles, then captures the ALU result and carry, derives flags, and returns them on a valid/ready response interface.
- Sits between the instruction/test sequencer and the combinational ALU (decoder, mux, adder/subtractor).

## Interface
Parameters:
- WIDTH, 8, operand/result width
- LAT, 1, ALU settle cycles before capture (≥1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_op  in  3  ALU opcode
- cmd_a, cmd_b  in  WIDTH  operands
- alu_op  out  3  registered opcode to ALU decoder
- alu_a, alu_b  out  WIDTH  registered operands to ALU
- alu_y  in  WIDTH  ALU result
- alu_cout  in  1  ALU adder/subtractor carry-out
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when high with rsp_valid
- rsp_y  out  WIDTH  captured result
- rsp_op  out  3  opcode of this response
- rsp_c  out  1  carry, arithmetic ops only
- rsp_z  out  1  rsp_y == 0
- busy  out  1  state != IDLE
- done_cnt  out  16  completed responses, wraps

## Operation
- FSM states IDLE, EXEC, RESP.
- IDLE: cmd_ready=1. On accept, latch cmd_op/a/b into alu_op/a/b, load wait counter with LAT-1, go EXEC.
- EXEC: alu_* held. Counter decrements each cycle. When counter==0, capture alu_y into rsp_y, alu_op into rsp_op, flags into rsp_c/rsp_z; go RESP.
- RESP: rsp_valid=1, all rsp_* stable until handshake.
  - On rsp_valid&&rsp_ready: done_cnt++ (0xFFFF→0x0000).
  - If cmd_valid is also high, accept the new command in the same cycle and go EXEC; otherwise go IDLE.
- cmd_ready = (IDLE) | (RESP & rsp_ready). Deasserted during rst.
- Arithmetic class: opcodes 000, 010, 011, 101, 111 (decoder selects adder/subtractor). rsp_c = alu_cout for these; rsp_c = 0 for 001, 100, 110.
- rsp_z computed from the captured alu_y, full WIDTH.
- alu_* keep their last values after capture until the next accept; no toggling while idle.

## Timing
- Reset values: state IDLE; cmd_ready=0 while rst high, 1 the cycle after rst falls; rsp_valid=0, busy=0, alu_op=000, alu_a=alu_b=0, rsp_y=0, rsp_op=000, rsp_c=0, rsp_z=0, done_cnt=0.
- Accept in cycle t. alu_* valid from t+1. Capture at end of cycle t+LAT. rsp_valid high from t+LAT+1.
- Peak throughput: one command per LAT+1 cycles.
- alu_y/alu_cout are sampled only at the capture edge; values in earlier EXEC cycles are ignored.
- rst in any state takes effect at the next edge and overrides everything:
  - in-flight command discarded, no response;
  - pending response dropped;
  - done_cnt cleared.
- rsp_ready high while not rsp_valid has no effect. cmd_valid while cmd_ready low is not accepted; the source must hold it.

## Structure
- Shared package alu_pkg:
  - opcode constants OP_000..OP_111 with mnemonic aliases;
  - function is_arith(op) returning the arithmetic class above;
  - state enum.
  The ALU control decoder reuses the same package.
- One sub-module, alu_rsp_flags: combinational (op, y, cout) → (c, z). The FSM, counter and registers stay in the top.

## Test plan
- Reset: hold rst 2 cycles with cmd_valid=1 → cmd_ready=0, rsp_valid=0, alu_op=000, done_cnt=0. cmd_ready=1 the cycle after release.
- ADD, LAT=1: op 000, a=0xF0, b=0x20; ALU model y=0x10, cout=1 → rsp_valid at accept+2, rsp_y=0x10, rsp_c=1, rsp_z=0, rsp_op=000, done_cnt=1 after handshake.
- Logic op: op 001, a=0x0F, b=0xF0; model y=0x00, cout forced 1 → rsp_c=0, rsp_z=1.
- Backpressure and back-to-back:
  - rsp_ready low 5 cycles with second command pending → rsp_* stable and cmd_ready=0 throughout.
  - Raise rsp_ready → second command accepted in the same cycle as the handshake; its response follows 2 cycles later.
- LAT=3: alu_y model changes every cycle (0x11, 0x22, 0x33) → rsp_y=0x33, rsp_valid at accept+4.
- Reset mid-EXEC: assert rst one cycle after accept → no rsp_valid ever for that command, done_cnt=0.
- Counter wrap: preload via 65 536 transactions (or force) → done_cnt 0xFFFF→0x0000.

Source files
------------

// File: rtl/alu_cmd_issuer_pkg.sv
// Shared ALU definitions: opcode constants, arithmetic-class helper and the
// issuer state encoding. The ALU control decoder imports the same package so
// both sides agree on which opcodes route through the adder/subtractor.
package alu_pkg;

  typedef logic [2:0] opcode_t;

  localparam opcode_t OP_000 = 3'b000;
  localparam opcode_t OP_001 = 3'b001;
  localparam opcode_t OP_010 = 3'b010;
  localparam opcode_t OP_011 = 3'b011;
  localparam opcode_t OP_100 = 3'b100;
  localparam opcode_t OP_101 = 3'b101;
  localparam opcode_t OP_110 = 3'b110;
  localparam opcode_t OP_111 = 3'b111;

  // Mnemonic aliases; the decoder owns the exact operation behind each code.
  localparam opcode_t OP_ADD = OP_000;
  localparam opcode_t OP_AND = OP_001;
  localparam opcode_t OP_SUB = OP_010;
  localparam opcode_t OP_INC = OP_011;
  localparam opcode_t OP_OR  = OP_100;
  localparam opcode_t OP_DEC = OP_101;
  localparam opcode_t OP_XOR = OP_110;
  localparam opcode_t OP_NEG = OP_111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // True when the decoder selects the adder/subtractor, i.e. carry-out is
  // meaningful for this opcode.
  function automatic logic is_arith(input opcode_t op);
    case (op)
      OP_000, OP_010, OP_011, OP_101, OP_111: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Command, ALU-drive and response signals of the issuer in one bundle.
// slave: the issuer itself. master: sequencer plus combinational ALU.
interface alu_cmd_issuer_if #(
  parameter int WIDTH = 8
);
  import alu_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  opcode_t          cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;

  opcode_t          alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_y;
  logic             alu_cout;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_y;
  opcode_t          rsp_op;
  logic             rsp_c;
  logic             rsp_z;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b,
    input  alu_y, alu_cout,
    input  rsp_ready,
    output cmd_ready,
    output alu_op, alu_a, alu_b,
    output rsp_valid, rsp_y, rsp_op, rsp_c, rsp_z
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b,
    output alu_y, alu_cout,
    output rsp_ready,
    input  cmd_ready,
    input  alu_op, alu_a, alu_b,
    input  rsp_valid, rsp_y, rsp_op, rsp_c, rsp_z
  );

endinterface

// File: rtl/alu_cmd_issuer_rsp_flags.sv
// Response flag derivation from the ALU outputs present at the capture edge.
// Carry only means something for adder/subtractor opcodes; zero looks at the
// full result width.
module alu_rsp_flags
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  opcode_t          op,
  input  logic [WIDTH-1:0] y,
  input  logic             cout,
  output logic             c,
  output logic             z
);

  // Mask carry for logic ops, flag an all-zero result.
  always_comb begin
    c = is_arith(op) ? cout : 1'b0;
    z = (y == '0);
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// ALU command issuer: accepts one command, holds opcode/operands on the ALU
// for LAT cycles, captures result and flags, then presents them as a
// response. A response handshake can overlap with the next command accept,
// giving one command every LAT+1 cycles at best.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LAT   = 1
) (
  input  logic            clk,
  input  logic            rst,
  alu_cmd_issuer_if.slave bus,
  output logic            busy,
  output logic [15:0]     done_cnt
);

  // Wait counter only needs to hold LAT-1.
  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;

  logic             cmd_ready;
  logic             rsp_valid;
  logic             accept;
  logic             capture;
  logic             rsp_hs;

  opcode_t          alu_op_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;

  logic [WIDTH-1:0] rsp_y_q;
  opcode_t          rsp_op_q;
  logic             rsp_c_q;
  logic             rsp_z_q;
  logic             flag_c;
  logic             flag_z;

  logic [15:0]      done_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state: a response handshake with a waiting command goes straight
  // back to EXEC instead of passing through IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.cmd_valid) state_d = ST_EXEC;
      ST_EXEC: if (cnt_q == '0)   state_d = ST_RESP;
      ST_RESP: begin
        if (bus.rsp_ready) state_d = bus.cmd_valid ? ST_EXEC : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs and datapath strobes; cmd_ready is held low during reset
  // so nothing is accepted on the reset edge.
  always_comb begin
    cmd_ready = !rst && ((state_q == ST_IDLE) ||
                         ((state_q == ST_RESP) && bus.rsp_ready));
    rsp_valid = (state_q == ST_RESP);
    busy      = (state_q != ST_IDLE);
    accept    = bus.cmd_valid && cmd_ready;
    capture   = (state_q == ST_EXEC) && (cnt_q == '0);
    rsp_hs    = rsp_valid && bus.rsp_ready;
  end

  // Settle counter: loaded on accept, counts down while executing.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= CNT_LOAD;
    end else if ((state_q == ST_EXEC) && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // ALU drive registers: change only on accept so the ALU inputs stay quiet
  // between commands.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_op_q <= OP_000;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
    end else if (accept) begin
      alu_op_q <= bus.cmd_op;
      alu_a_q  <= bus.cmd_a;
      alu_b_q  <= bus.cmd_b;
    end
  end

  alu_rsp_flags #(
    .WIDTH (WIDTH)
  ) u_flags (
    .op   (alu_op_q),
    .y    (bus.alu_y),
    .cout (bus.alu_cout),
    .c    (flag_c),
    .z    (flag_z)
  );

  // Response capture: ALU outputs are sampled only on the last EXEC cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_y_q  <= '0;
      rsp_op_q <= OP_000;
      rsp_c_q  <= 1'b0;
      rsp_z_q  <= 1'b0;
    end else if (capture) begin
      rsp_y_q  <= bus.alu_y;
      rsp_op_q <= alu_op_q;
      rsp_c_q  <= flag_c;
      rsp_z_q  <= flag_z;
    end
  end

  // Completed-response counter, wraps at 16 bits.
  always_ff @(posedge clk) begin
    if (rst)         done_q <= '0;
    else if (rsp_hs) done_q <= done_q + 16'd1;
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.alu_op    = alu_op_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_y     = rsp_y_q;
  assign bus.rsp_op    = rsp_op_q;
  assign bus.rsp_c     = rsp_c_q;
  assign bus.rsp_z     = rsp_z_q;
  assign done_cnt      = done_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: directed scenarios on a LAT=1 and a LAT=3
// instance plus a randomized run scored against a transaction-level model.
module tb_alu_cmd_issuer;
  import alu_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] exp_done1 = 16'd0;
  logic [15:0] exp_done3 = 16'd0;

  alu_cmd_issuer_if #(.WIDTH(W)) if1 ();
  alu_cmd_issuer_if #(.WIDTH(W)) if3 ();
  logic        busy1, busy3;
  logic [15:0] done1, done3;

  alu_cmd_issuer #(.WIDTH(W), .LAT(1)) u1 (
    .clk(clk), .rst(rst), .bus(if1), .busy(busy1), .done_cnt(done1));
  alu_cmd_issuer #(.WIDTH(W), .LAT(3)) u3 (
    .clk(clk), .rst(rst), .bus(if3), .busy(busy3), .done_cnt(done3));

  // Behavioural ALU: {carry, result}.
  function automatic logic [W:0] alu_model(input logic [2:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    case (op)
      3'b000:  return {1'b0, a} + {1'b0, b};
      3'b001:  return {^a, a & b};
      3'b010:  return {1'b0, a} - {1'b0, b};
      3'b011:  return {1'b0, a} + (W+1)'(1);
      3'b100:  return {^b, a | b};
      3'b101:  return {1'b0, a} - (W+1)'(1);
      3'b110:  return {1'b1, a ^ b};
      default: return (W+1)'(0) - {1'b0, a};
    endcase
  endfunction

  function automatic logic tb_arith(input logic [2:0] op);
    return (op == 3'b000) || (op == 3'b010) || (op == 3'b011) ||
           (op == 3'b101) || (op == 3'b111);
  endfunction

  logic         mode1 = 1'b0, mode3 = 1'b0;
  logic [W-1:0] man_y1 = '0, man_y3 = '0;
  logic         man_c1 = 1'b0, man_c3 = 1'b0;
  logic [W:0]   m1, m3;

  assign m1 = alu_model(if1.alu_op, if1.alu_a, if1.alu_b);
  assign m3 = alu_model(if3.alu_op, if3.alu_a, if3.alu_b);
  assign if1.alu_y    = mode1 ? m1[W-1:0] : man_y1;
  assign if1.alu_cout = mode1 ? m1[W]     : man_c1;
  assign if3.alu_y    = mode3 ? m3[W-1:0] : man_y3;
  assign if3.alu_cout = mode3 ? m3[W]     : man_c3;

  task automatic test_reset;
    rst = 1'b1;
    if1.cmd_valid = 1'b1; if1.cmd_op = 3'b101; if1.cmd_a = 8'hAA; if1.cmd_b = 8'h55;
    if3.cmd_valid = 1'b1; if3.cmd_op = 3'b011; if3.cmd_a = 8'h12; if3.cmd_b = 8'h34;
    if1.rsp_ready = 1'b0; if3.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++; if (if1.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 0", if1.cmd_ready); end
    n_chk++; if (if1.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", if1.rsp_valid); end
    n_chk++; if (if1.alu_op !== 3'b000) begin n_fail++; $display("FAIL reset_alu_op: got %b want 000", if1.alu_op); end
    n_chk++; if (if1.alu_a !== 8'h00) begin n_fail++; $display("FAIL reset_alu_a: got %h want 00", if1.alu_a); end
    n_chk++; if (done1 !== 16'h0000) begin n_fail++; $display("FAIL reset_done: got %h want 0000", done1); end
    n_chk++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy1); end
    n_chk++; if (if3.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready3: got %b want 0", if3.cmd_ready); end
    n_chk++; if ({if1.rsp_y, if1.rsp_op, if1.rsp_c, if1.rsp_z} !== 13'h0) begin n_fail++; $display("FAIL reset_rsp_fields: got %h want 0", {if1.rsp_y, if1.rsp_op, if1.rsp_c, if1.rsp_z}); end
    rst = 1'b0;
    if1.cmd_valid = 1'b0; if3.cmd_valid = 1'b0;
    #1;
    n_chk++; if (if1.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL release_cmd_ready: got %b want 1", if1.cmd_ready); end
    n_chk++; if (if3.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL release_cmd_ready3: got %b want 1", if3.cmd_ready); end
  endtask

  task automatic test_add;
    @(negedge clk);
    mode1 = 1'b0; man_y1 = 8'h10; man_c1 = 1'b1;
    if1.cmd_valid = 1'b1; if1.cmd_op = 3'b000; if1.cmd_a = 8'hF0; if1.cmd_b = 8'h20;
    @(posedge clk);
    @(negedge clk);
    if1.cmd_valid = 1'b0;
    n_chk++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL add_busy: got %b want 1", busy1); end
    n_chk++; if ({if1.alu_op, if1.alu_a, if1.alu_b} !== {3'b000, 8'hF0, 8'h20}) begin n_fail++; $display("FAIL add_alu_drive: got %h want %h", {if1.alu_op, if1.alu_a, if1.alu_b}, {3'b000, 8'hF0, 8'h20}); end
    n_chk++; if (if1.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL add_early_valid: got %b want 0", if1.rsp_valid); end
    @(posedge clk);
    @(negedge clk);
    n_chk++; if (if1.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL add_rsp_valid: got %b want 1", if1.rsp_valid); end
    n_chk++; if ({if1.rsp_y, if1.rsp_op, if1.rsp_c, if1.rsp_z} !== {8'h10, 3'b000, 1'b1, 1'b0}) begin n_fail++; $display("FAIL add_rsp: got %h want %h", {if1.rsp_y, if1.rsp_op, if1.rsp_c, if1.rsp_z}, {8'h10, 3'b000, 1'b1, 1'b0}); end
    if1.rsp_ready = 1'b1;
    @(posedge clk);
    exp_done1 = exp_done1 + 16'd1;
    @(negedge clk);
    if1.rsp_ready = 1'b0;
    n_chk++; if (done1 !== exp_done1) begin n_fail++; $display("FAIL add_done: got %h want %h", done1, exp_done1); end
    n_chk++; if (if1.rsp_valid !== 1'b0 || busy1 !== 1'b0) begin n_fail++; $display("FAIL add_idle: got valid=%b busy=%b want 0 0", if1.rsp_valid, busy1); end
    n_chk++; if (if1.alu_a !== 8'hF0) begin n_fail++; $display("FAIL add_alu_hold: got %h want F0", if1.alu_a); end
  endtask

  task automatic test_logic;
    @(negedge clk);
    man_y1 = 8'h00; man_c1 = 1'b1;
    if1.cmd_valid = 1'b1; if1.cmd_op = 3'b001; if1.cmd_a = 8'h0F; if1.cmd_b = 8'hF0;
    @(posedge clk);
    @(negedge clk);
    if1.cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_chk++; if (if1.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL logic_rsp_valid: got %b want 1", if1.rsp_valid); end
    n_chk++; if ({if1.rsp_op, if1.rsp_c, if1.rsp_z} !== {3'b001, 1'b0, 1'b1}) begin n_fail++; $display("FAIL logic_flags: got %b want %b", {if1.rsp_op, if1.rsp_c, if1.rsp_z}, {3'b001, 1'b0, 1'b1}); end
    if1.rsp_ready = 1'b1;
    @(posedge clk);
    exp_done1 = exp_done1 + 16'd1;
    @(negedge clk);
    if1.rsp_ready = 1'b0;
    n_chk++; if (done1 !== exp_done1) begin n_fail++; $display("FAIL logic_done: got %h want %h", done1, exp_done1); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    man_y1 = 8'h02; man_c1 = 1'b1;
    if1.cmd_valid = 1'b1; if1.cmd_op = 3'b010; if1.cmd_a = 8'h05; if1.cmd_b = 8'h03;
    @(posedge clk);
    @(negedge clk);
    if1.cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    // second command waits while the first response is back-pressured
    if1.cmd_valid = 1'b1; if1.cmd_op = 3'b100; if1.cmd_a = 8'h30; if1.cmd_b = 8'h0C;
    man_y1 = 8'h3C; man_c1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_chk++; if (if1.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL bp_cmd_ready[%0d]: got %b want 0", i, if1.cmd_ready); end
      n_chk++; if ({if1.rsp_valid, if1.rsp_y, if1.rsp_op, if1.rsp_c, if1.rsp_z} !== {1'b1, 8'h02, 3'b010, 1'b1, 1'b0}) begin n_fail++; $display("FAIL bp_rsp_stable[%0d]: got %h want %h", i, {if1.rsp_valid, if1.rsp_y, if1.rsp_op, if1.rsp_c, if1.rsp_z}, {1'b1, 8'h02, 3'b010, 1'b1, 1'b0}); end
      @(negedge clk);
    end
    if1.rsp_ready = 1'b1;
    #1;
    n_chk++; if (if1.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_cmd_ready: got %b want 1", if1.cmd_ready); end
    @(posedge clk);
    exp_done1 = exp_done1 + 16'd1;
    @(negedge clk);
    if1.cmd_valid = 1'b0; if1.rsp_ready = 1'b0;
    n_chk++; if (if1.rsp_valid !== 1'b0 || busy1 !== 1'b1 || if1.alu_op !== 3'b100) begin n_fail++; $display("FAIL b2b_exec: got valid=%b busy=%b op=%b want 0 1 100", if1.rsp_valid, busy1, if1.alu_op); end
    n_chk++; if (done1 !== exp_done1) begin n_fail++; $display("FAIL b2b_done1: got %h want %h", done1, exp_done1); end
    @(posedge clk);
    @(negedge clk);
    n_chk++; if ({if1.rsp_valid, if1.rsp_y, if1.rsp_op, if1.rsp_c, if1.rsp_z} !== {1'b1, 8'h3C, 3'b100, 1'b0, 1'b0}) begin n_fail++; $display("FAIL b2b_second_rsp: got %h want %h", {if1.rsp_valid, if1.rsp_y, if1.rsp_op, if1.rsp_c, if1.rsp_z}, {1'b1, 8'h3C, 3'b100, 1'b0, 1'b0}); end
    if1.rsp_ready = 1'b1;
    @(posedge clk);
    exp_done1 = exp_done1 + 16'd1;
    @(negedge clk);
    if1.rsp_ready = 1'b0;
    n_chk++; if (done1 !== exp_done1) begin n_fail++; $display("FAIL b2b_done2: got %h want %h", done1, exp_done1); end
  endtask

  task automatic test_lat3;
    logic [W-1:0] seq_y [3];
    logic         seq_c [3];
    seq_y[0] = 8'h11; seq_y[1] = 8'h22; seq_y[2] = 8'h33;
    seq_c[0] = 1'b0;  seq_c[1] = 1'b0;  seq_c[2] = 1'b1;
    @(negedge clk);
    mode3 = 1'b0; man_y3 = 8'h77; man_c3 = 1'b0;
    if3.cmd_valid = 1'b1; if3.cmd_op = 3'b000; if3.cmd_a = 8'h10; if3.cmd_b = 8'h23;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if3.cmd_valid = 1'b0;
      man_y3 = seq_y[i]; man_c3 = seq_c[i];
      n_chk++; if (if3.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL lat3_early_valid[%0d]: got %b want 0", i, if3.rsp_valid); end
    end
    @(negedge clk);
    man_y3 = 8'h99;
    n_chk++; if (if3.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL lat3_rsp_valid: got %b want 1", if3.rsp_valid); end
    n_chk++; if ({if3.rsp_y, if3.rsp_c, if3.rsp_z} !== {8'h33, 1'b1, 1'b0}) begin n_fail++; $display("FAIL lat3_rsp: got %h want %h", {if3.rsp_y, if3.rsp_c, if3.rsp_z}, {8'h33, 1'b1, 1'b0}); end
    if3.rsp_ready = 1'b1;
    @(posedge clk);
    exp_done3 = exp_done3 + 16'd1;
    @(negedge clk);
    if3.rsp_ready = 1'b0;
    n_chk++; if (done3 !== exp_done3) begin n_fail++; $display("FAIL lat3_done: got %h want %h", done3, exp_done3); end
  endtask

  task automatic test_random;
    logic [2:0]   q_op [$];
    logic [W-1:0] q_y  [$];
    logic         q_c  [$];
    logic         q_z  [$];
    int           q_t  [$];
    logic [W:0]   r;
    logic         pend;
    logic         exp_v, exp_rdy;
    int           issued;
    int           target;
    pend = 1'b0; issued = 0; target = 150;
    mode3 = 1'b1;
    for (int k = 0; k < 6000 && (issued < target || q_t.size() > 0); k++) begin
      @(negedge clk);
      if (!pend) begin
        if3.cmd_valid = 1'b0;
        if (issued < target && $urandom_range(0, 9) < 7) begin
          pend = 1'b1;
          if3.cmd_valid = 1'b1;
          if3.cmd_op = 3'($urandom);
          if3.cmd_a  = W'($urandom);
          if3.cmd_b  = (($urandom_range(0, 3) == 0) ? if3.cmd_a : W'($urandom));
        end
      end
      if3.rsp_ready = 1'($urandom_range(0, 1));
      #1;
      exp_v   = (q_t.size() > 0) && (cyc >= q_t[0] + 4);
      exp_rdy = (q_t.size() == 0) || (exp_v && if3.rsp_ready);
      n_chk++; if (if3.rsp_valid !== exp_v) begin n_fail++; $display("FAIL rnd_rsp_valid@%0d: got %b want %b", cyc, if3.rsp_valid, exp_v); end
      n_chk++; if (if3.cmd_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_cmd_ready@%0d: got %b want %b", cyc, if3.cmd_ready, exp_rdy); end
      n_chk++; if (done3 !== exp_done3) begin n_fail++; $display("FAIL rnd_done@%0d: got %h want %h", cyc, done3, exp_done3); end
      if (exp_v) begin
        n_chk++;
        if ({if3.rsp_y, if3.rsp_op, if3.rsp_c, if3.rsp_z} !== {q_y[0], q_op[0], q_c[0], q_z[0]}) begin
          n_fail++;
          $display("FAIL rnd_rsp@%0d: got y=%h op=%b c=%b z=%b want y=%h op=%b c=%b z=%b", cyc,
                   if3.rsp_y, if3.rsp_op, if3.rsp_c, if3.rsp_z, q_y[0], q_op[0], q_c[0], q_z[0]);
        end
        if (if3.rsp_ready) begin
          void'(q_y.pop_front()); void'(q_op.pop_front());
          void'(q_c.pop_front()); void'(q_z.pop_front()); void'(q_t.pop_front());
          exp_done3 = exp_done3 + 16'd1;
        end
      end
      if (if3.cmd_valid && exp_rdy) begin
        r = alu_model(if3.cmd_op, if3.cmd_a, if3.cmd_b);
        q_op.push_back(if3.cmd_op);
        q_y.push_back(r[W-1:0]);
        q_c.push_back(tb_arith(if3.cmd_op) ? r[W] : 1'b0);
        q_z.push_back(r[W-1:0] == '0);
        q_t.push_back(cyc);
        issued++;
        pend = 1'b0;
      end
    end
    n_chk++; if (issued != target || q_t.size() != 0) begin n_fail++; $display("FAIL rnd_timeout: got issued=%0d pending=%0d want %0d 0", issued, q_t.size(), target); end
    @(negedge clk);
    if3.cmd_valid = 1'b0; if3.rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_exec;
    @(negedge clk);
    mode1 = 1'b0; man_y1 = 8'h5A; man_c1 = 1'b1;
    if1.cmd_valid = 1'b1; if1.cmd_op = 3'b000; if1.cmd_a = 8'h2D; if1.cmd_b = 8'h2D;
    @(posedge clk);
    @(negedge clk);
    if1.cmd_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    exp_done1 = 16'd0; exp_done3 = 16'd0;
    @(negedge clk);
    rst = 1'b0;
    n_chk++; if (busy1 !== 1'b0 || done1 !== exp_done1 || done3 !== exp_done3) begin n_fail++; $display("FAIL rstmid_state: got busy=%b done1=%h done3=%h want 0 0 0", busy1, done1, done3); end
    n_chk++; if (if1.rsp_y !== 8'h00) begin n_fail++; $display("FAIL rstmid_rsp_y: got %h want 00", if1.rsp_y); end
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (if1.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_rsp[%0d]: got %b want 0", i, if1.rsp_valid); end
      @(negedge clk);
    end
  endtask

  task automatic test_wrap;
    @(negedge clk);
    mode1 = 1'b1;
    force u1.done_q = 16'hFFFE;
    #1;
    release u1.done_q;
    exp_done1 = 16'hFFFE;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if1.cmd_valid = 1'b1; if1.cmd_op = 3'($urandom); if1.cmd_a = W'($urandom); if1.cmd_b = W'($urandom);
      @(posedge clk);
      @(negedge clk);
      if1.cmd_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_chk++; if (if1.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_rsp_valid[%0d]: got %b want 1", i, if1.rsp_valid); end
      if1.rsp_ready = 1'b1;
      @(posedge clk);
      exp_done1 = exp_done1 + 16'd1;
      @(negedge clk);
      if1.rsp_ready = 1'b0;
      n_chk++; if (done1 !== exp_done1) begin n_fail++; $display("FAIL wrap_done[%0d]: got %h want %h", i, done1, exp_done1); end
    end
  endtask

  initial begin
    rst = 1'b1;
    if1.cmd_valid = 1'b0; if1.cmd_op = 3'b000; if1.cmd_a = '0; if1.cmd_b = '0; if1.rsp_ready = 1'b0;
    if3.cmd_valid = 1'b0; if3.cmd_op = 3'b000; if3.cmd_a = '0; if3.cmd_b = '0; if3.rsp_ready = 1'b0;
    test_reset();
    test_add();
    test_logic();
    test_back_to_back();
    test_lat3();
    test_random();
    test_reset_mid_exec();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
